// File: rtl/ctx_pkg.sv
`default_nettype none
// ============================================================================
// Package : ctx_pkg
// Brief   : Shared types and constants for the context-switch controller.
// Rev     : 1.0  initial release
// ============================================================================
package ctx_pkg;

  // Number of hardware register contexts and the id width that selects one
  localparam int NCTX    = 4;
  localparam int CTX_W   = 2;

  // Architectural register file: 32 registers, x0 included
  localparam int REG_CNT = 32;
  localparam int REG_AW  = 5;

  // Context memory address is {ctx, reg index}
  localparam int CM_AW   = CTX_W + REG_AW;

  // Walk index must reach REG_CNT (one beyond the last register) during restore
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } ctx_state_e;

endpackage : ctx_pkg
`default_nettype wire

// File: rtl/ctx_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ctx_switch_ctrl
// Brief   : Saves the live register file into an external context memory and
//           restores another context from it, stalling the pipeline while the
//           register file is owned by the controller.
// Rev     : 1.0  initial release
// ============================================================================
module ctx_switch_ctrl
  import ctx_pkg::*;
#(
  parameter int NCTX  = ctx_pkg::NCTX,
  parameter int CTX_W = ctx_pkg::CTX_W
) (
  input  logic                     CLK,
  input  logic                     RESET,

  // Switch request handshake
  input  logic                     SW_REQ,
  input  logic [CTX_W-1:0]         OLD_CTX,
  input  logic [CTX_W-1:0]         NEW_CTX,
  output logic                     SW_ACK,
  output logic                     BUSY,

  // Pipeline write port
  input  logic                     CPU_WRITE,
  input  logic [REG_AW-1:0]        CPU_INADDRESS,
  input  logic [31:0]              CPU_IN,

  // Muxed register-file write port
  output logic                     RF_WRITE,
  output logic [REG_AW-1:0]        RF_INADDRESS,
  output logic [31:0]              RF_IN,

  // Register-file read port used while saving
  output logic [REG_AW-1:0]        RF_RDADDR,
  input  logic [31:0]              RF_RDDATA,

  // External context memory
  output logic [CTX_W+REG_AW-1:0]  CM_ADDR,
  output logic                     CM_WE,
  output logic [31:0]              CM_WDATA,
  input  logic [31:0]              CM_RDATA
);

  // Last index of the save walk, and the extra restore step that drains the
  // one-cycle read latency of the context memory
  localparam logic [IDX_W-1:0] c_save_last = IDX_W'(REG_CNT - 1);
  localparam logic [IDX_W-1:0] c_rest_last = IDX_W'(REG_CNT);

  ctx_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [CTX_W-1:0]   old_q,   old_d;
  logic [CTX_W-1:0]   new_q,   new_d;

  logic [CTX_W-1:0]   w_old_ctx;
  logic [CTX_W-1:0]   w_new_ctx;
  logic [IDX_W-1:0]   w_idx_m1;

  // When fewer contexts exist than the id width can encode, out-of-range ids
  // are clamped to the last real context so the memory is never overrun.
  if (NCTX == (1 << CTX_W)) begin : g_ids_full
    assign w_old_ctx = OLD_CTX;
    assign w_new_ctx = NEW_CTX;
  end else begin : g_ids_clamp
    localparam logic [CTX_W-1:0] c_last_ctx = CTX_W'(NCTX - 1);
    assign w_old_ctx = (OLD_CTX > c_last_ctx) ? c_last_ctx : OLD_CTX;
    assign w_new_ctx = (NEW_CTX > c_last_ctx) ? c_last_ctx : NEW_CTX;
  end

  // Restore writes trail the memory read by one cycle
  assign w_idx_m1 = idx_q - IDX_W'(1);

  // State, walk index and latched context ids; reset acts without a clock
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      old_q   <= '0;
      new_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      old_q   <= old_d;
      new_q   <= new_d;
    end
  end

  // Next-state: accept a request, walk 32 saves, 33 restore steps, then ack
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    old_d   = old_q;
    new_d   = new_q;
    case (state_q)
      ST_IDLE: begin
        if (SW_REQ) begin
          old_d   = w_old_ctx;
          new_d   = w_new_ctx;
          idx_d   = '0;
          state_d = (w_old_ctx == w_new_ctx) ? ST_DONE : ST_SAVE;
        end
      end
      ST_SAVE: begin
        if (idx_q == c_save_last) begin
          idx_d   = '0;
          state_d = ST_RESTORE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_RESTORE: begin
        if (idx_q == c_rest_last) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: CPU pass-through when idle, controller owns the ports otherwise
  always_comb begin
    SW_ACK       = 1'b0;
    BUSY         = 1'b1;
    RF_WRITE     = 1'b0;
    RF_INADDRESS = CPU_INADDRESS;
    RF_IN        = CPU_IN;
    RF_RDADDR    = '0;
    CM_ADDR      = '0;
    CM_WE        = 1'b0;
    CM_WDATA     = RF_RDDATA;
    case (state_q)
      ST_IDLE: begin
        BUSY     = 1'b0;
        // A write during reset must not reach the register file
        RF_WRITE = CPU_WRITE & ~RESET;
      end
      ST_SAVE: begin
        RF_RDADDR = idx_q[REG_AW-1:0];
        CM_ADDR   = {old_q, idx_q[REG_AW-1:0]};
        CM_WE     = 1'b1;
      end
      ST_RESTORE: begin
        // At the final drain step the address wraps to 0; the read is unused
        CM_ADDR      = {new_q, idx_q[REG_AW-1:0]};
        RF_WRITE     = (idx_q != '0);
        RF_INADDRESS = w_idx_m1[REG_AW-1:0];
        RF_IN        = CM_RDATA;
      end
      ST_DONE: begin
        SW_ACK = 1'b1;
      end
      default: begin
        BUSY = 1'b1;
      end
    endcase
  end

endmodule : ctx_switch_ctrl
`default_nettype wire

// File: doc/ctx_switch_ctrl.md
CTX_SWITCH_CTRL -- requirements
Module: ctx_switch_ctrl

Interface
REQ-001 Parameter NCTX, default 4, number of hardware register contexts held in context memory.
REQ-002 Parameter CTX_W, default 2, context-id width, equal to log2(NCTX).
REQ-003 CLK  in  1  clock; all state updates on the posedge.
REQ-004 RESET  in  1  reset, asynchronous, active-high.
REQ-005 SW_REQ  in  1  context-switch request, level, held until SW_ACK.
REQ-006 OLD_CTX  in  CTX_W  context id to save the register file into.
REQ-007 NEW_CTX  in  CTX_W  context id to restore the register file from.
REQ-008 SW_ACK  out  1  one-cycle completion pulse.
REQ-009 BUSY  out  1  high in any non-IDLE state; the pipeline stalls on it.
REQ-010 CPU_WRITE, CPU_INADDRESS, CPU_IN  in  1/5/32  pipeline write port.
REQ-011 RF_WRITE, RF_INADDRESS, RF_IN  out  1/5/32  muxed register-file write port.
REQ-012 RF_RDADDR  out  5  register-file read address used during save.
REQ-013 RF_RDDATA  in  32  register-file read data, combinational from RF_RDADDR.
REQ-014 CM_ADDR  out  CTX_W+5  context-memory address, formed as {ctx, reg index}.
REQ-015 CM_WE, CM_WDATA  out  1/32  context-memory write enable and data.
REQ-016 CM_RDATA  in  32  context-memory read data, one-cycle synchronous latency.

Function
REQ-017 States SHALL be IDLE, SAVE, RESTORE and DONE, held in a registered state with a registered 6-bit index idx.
REQ-018 IDLE: RF_* outputs SHALL equal CPU_* (pass-through), CM_WE=0 and BUSY=0.
REQ-019 IDLE with SW_REQ=1 SHALL latch OLD_CTX/NEW_CTX, clear idx and go to SAVE, or go to DONE if OLD_CTX==NEW_CTX.
REQ-020 A CPU write in the acceptance cycle SHALL complete, and the subsequent save SHALL capture it.
REQ-021 SAVE, idx 0..31, one register per cycle: RF_RDADDR=idx, CM_WE=1, CM_ADDR={old,idx}, CM_WDATA=RF_RDDATA; idx 31 -> RESTORE with idx cleared; 32 cycles.
REQ-022 RESTORE SHALL issue CM_ADDR={new,idx} for idx 0..31, with CM_WE=0.
REQ-023 In the cycle after each RESTORE read, RF_WRITE=1, RF_INADDRESS=idx-1 and RF_IN=CM_RDATA; RESTORE SHALL last 33 cycles, idx 0..32, with no write at idx 0.
REQ-024 DONE SHALL assert SW_ACK=1 for exactly one cycle with BUSY=1, then go to IDLE.
REQ-025 Total latency SHALL be 66 cycles from the acceptance edge to the SW_ACK cycle (1+32+33), or 1 cycle when the ids are equal.
REQ-026 While BUSY=1, CPU_WRITE SHALL be ignored, RF_WRITE SHALL be driven only by the controller, and no CPU write SHALL reach the register file.
REQ-027 Changes on OLD_CTX/NEW_CTX after acceptance SHALL have no effect.
REQ-028 SW_REQ still high in IDLE after DONE SHALL start a new switch, so the requester drops SW_REQ on seeing SW_ACK.
REQ-029 Register x0 SHALL be saved and restored like every other register, with no hardwired zero.

Reset
REQ-030 RESET=1 SHALL force state IDLE, idx=0 and latched ids=0 immediately, without waiting for CLK.
REQ-031 During RESET: BUSY=0, SW_ACK=0, CM_WE=0 and RF_WRITE=0, and RF_WRITE SHALL be gated off even if CPU_WRITE=1.
REQ-032 RESET mid-SAVE/RESTORE SHALL abandon the switch with no SW_ACK; partially written context-memory contents are undefined.

Structure
REQ-033 Shared package ctx_pkg SHALL hold the state enum, NCTX, CTX_W, REG_CNT=32 and CM_AW=CTX_W+5.
REQ-034 The block SHALL be a single module (FSM, index counter, output mux) with no sub-module; the context memory is external.

Verification
REQ-035 Preload the register file with r[i]=0x100+i, request old=1 new=2 with ctx2 preloaded 0x200+i -> CM[{1,i}]=0x100+i, r[i]=0x200+i, SW_ACK 66 cycles after acceptance.
REQ-036 Request old=3 new=3 -> no CM_WE or RF_WRITE, SW_ACK one cycle after acceptance, register file unchanged.
REQ-037 CPU_WRITE r5=0xDEAD in the acceptance cycle -> CM[{old,5}]=0xDEAD; CPU_WRITE r7=0xBEEF during SAVE -> r7 not written, final r7 from context.
REQ-038 Assert RESET at SAVE idx 10 -> BUSY=0 and CM_WE=0 asynchronously, no SW_ACK; a new request completes normally.
REQ-039 Hold SW_REQ high two cycles past SW_ACK -> second switch starts from IDLE; flip OLD_CTX mid-SAVE -> CM_ADDR context unchanged.
